pattern_sequencer: RTL and testbench
====================================

PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 SHALL have parameter FIRST_PATTERN, default 1, lowest pattern index in the cycle.
REQ-002 SHALL have parameter LAST_PATTERN, default 6, highest pattern index in the cycle; FIRST_PATTERN < LAST_PATTERN <= 15.
REQ-003 SHALL have port i_Clk  input  1  system/pixel clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_VSync  input  1  raw vertical sync; a rising edge marks frame start.
REQ-006 SHALL have port i_Next  input  1  single-cycle pulse (already debounced): advance one pattern.
REQ-007 SHALL have port i_Prev  input  1  single-cycle pulse (already debounced): step back one pattern.
REQ-008 SHALL have port i_Auto_En  input  1  level: enable timed auto-advance.
REQ-009 SHALL have port i_Frames_Per_Pattern  input  8  auto-advance dwell in frames; 0 means no auto-advance.
REQ-010 SHALL have port o_Pattern  output  4  pattern select for the test pattern generator.
REQ-011 SHALL have port o_Frame_Start  output  1  one-cycle pulse per detected frame start.
REQ-012 SHALL have port o_Pending  output  1  a manual step is latched and waiting for a frame start.

Function
REQ-013 SHALL detect frame start as i_VSync high with the previous-cycle registered i_VSync low; o_Frame_Start is registered and asserts the cycle after the detection cycle.
REQ-014 SHALL update o_Pattern only on the clock edge ending a frame-start detection cycle, so o_Pattern never changes mid-frame.
REQ-015 SHALL implement states ST_BLANK, ST_SHOW and ST_PENDING.
REQ-016 ST_BLANK: o_Pattern=0; on the first frame start -> ST_SHOW with o_Pattern=FIRST_PATTERN; i_Next/i_Prev are ignored in this state.
REQ-017 ST_SHOW: an i_Next or i_Prev pulse latches a direction -> ST_PENDING, o_Pending=1 from the next cycle.
REQ-018 ST_PENDING: at frame start, step o_Pattern in the latched direction, clear o_Pending, clear the frame counter, -> ST_SHOW.
REQ-019 SHALL wrap: next from LAST_PATTERN gives FIRST_PATTERN; prev from FIRST_PATTERN gives LAST_PATTERN.
REQ-020 SHALL not accumulate repeated pulses of the same direction in ST_PENDING (one step per frame); a pulse of the opposite direction in ST_PENDING cancels the pending step -> ST_SHOW, o_Pending=0.
REQ-021 SHALL ignore i_Next and i_Prev asserted together in the same cycle (no state change).
REQ-022 SHALL treat a pulse that coincides with a frame-start detection cycle as arriving after that frame start (it is latched and applied at the following frame start).
REQ-023 SHALL keep an 8-bit frame counter that increments at each frame start in ST_SHOW when i_Auto_En=1 and i_Frames_Per_Pattern!=0.
REQ-024 When that increment would make the count equal i_Frames_Per_Pattern, SHALL instead advance o_Pattern (same wrap as REQ-019) and clear the counter to 0.
REQ-025 SHALL clear the frame counter whenever i_Auto_En=0 or i_Frames_Per_Pattern=0.
REQ-026 A manual step applied in ST_PENDING SHALL take priority over auto-advance at the same frame start (single step only).
REQ-027 A change of i_Frames_Per_Pattern to a value <= the current count SHALL cause an advance at the next frame start.

Reset
REQ-028 While i_Rst=1 at a clock edge: state=ST_BLANK, o_Pattern=0, o_Frame_Start=0, o_Pending=0, frame counter=0, pending direction cleared, registered VSync=0.
REQ-029 Reset asserted mid-operation (including in ST_PENDING) SHALL discard any pending step; reset SHALL take priority over all other inputs.

Verification
REQ-030 Reset, then 3 VSync rising edges, auto off -> o_Pattern 0, then 1 after the first edge, still 1 after the third; o_Frame_Start pulses 3 times.
REQ-031 In ST_SHOW at pattern 6, pulse i_Next mid-frame -> o_Pending=1, o_Pattern stays 6 until the next frame start, then 1; o_Pending=0.
REQ-032 At pattern 3, pulse i_Next three times then i_Prev within one frame -> after the frame start o_Pattern=3 (cancelled); at pattern 1, i_Prev alone -> 6.
REQ-033 i_Auto_En=1, i_Frames_Per_Pattern=2, starting at 1 -> o_Pattern 1,1,2,2,3 across successive frames; wraps 6 -> 1; i_Frames_Per_Pattern=0 -> holds.
REQ-034 i_Next and i_Prev in the same cycle -> no pending, no change; i_Next on a frame-start detection cycle -> applied at the following frame start.
REQ-035 Assert i_Rst in ST_PENDING at pattern 4 -> o_Pattern=0, o_Pending=0 next cycle; first frame start after release gives 1.

Source files
------------

// File: rtl/pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_sequencer
//
// Selects which test pattern a downstream generator draws. It changes only at
// frame boundaries, so a frame is never shown half in one pattern and half in
// another. The pattern can be stepped manually with the Next/Prev pulses,
// which wait for the next frame start, or advanced automatically every
// i_Frames_Per_Pattern frames.
//
// Parameters
//   FIRST_PATTERN        lowest pattern index in the cycle
//   LAST_PATTERN         highest pattern index in the cycle
//                        (FIRST_PATTERN < LAST_PATTERN <= 15)
//
// Ports
//   i_Clk                system/pixel clock; all logic on its rising edge
//   i_Rst                synchronous active-high reset
//   i_VSync              raw vertical sync; a rising edge marks frame start
//   i_Next / i_Prev      single-cycle step pulses, already debounced
//   i_Auto_En            level, enables timed auto-advance
//   i_Frames_Per_Pattern auto-advance dwell in frames (0 = no auto-advance)
//   o_Pattern            pattern select (0 until the first frame start)
//   o_Frame_Start        one-cycle pulse, the cycle after a frame start
//   o_Pending            a manual step is waiting for the next frame start
// -----------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int FIRST_PATTERN = 1,
    parameter int LAST_PATTERN  = 6
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_VSync,
    input  logic       i_Next,
    input  logic       i_Prev,
    input  logic       i_Auto_En,
    input  logic [7:0] i_Frames_Per_Pattern,
    output logic [3:0] o_Pattern,
    output logic       o_Frame_Start,
    output logic       o_Pending
);

    localparam logic [1:0] ST_BLANK   = 2'd0;
    localparam logic [1:0] ST_SHOW    = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;

    localparam logic [3:0] FIRST_P = 4'(FIRST_PATTERN);
    localparam logic [3:0] LAST_P  = 4'(LAST_PATTERN);

    logic [1:0] state;
    logic       vsync_q;
    logic [7:0] frame_count;
    logic       dir_next;      // latched direction: 1 = next, 0 = prev

    logic       frame_start_det;
    logic       single_pulse;
    logic       auto_active;
    logic       dwell_done;
    logic [3:0] pattern_inc;
    logic [3:0] pattern_dec;

    assign frame_start_det = i_VSync & ~vsync_q;
    // Next and Prev together cancel each other out and are ignored.
    assign single_pulse    = i_Next ^ i_Prev;
    assign auto_active     = i_Auto_En && (i_Frames_Per_Pattern != 8'd0);
    // Compare with >= so that lowering the dwell below the current count
    // still advances at the next frame start instead of counting to 255.
    assign dwell_done      = ({1'b0, frame_count} + 9'd1) >= {1'b0, i_Frames_Per_Pattern};
    assign pattern_inc     = (o_Pattern == LAST_P)  ? FIRST_P : o_Pattern + 4'd1;
    assign pattern_dec     = (o_Pattern == FIRST_P) ? LAST_P  : o_Pattern - 4'd1;

    assign o_Pending       = (state == ST_PENDING);

    // NOTE: every register here is assigned with <= so that all of them see
    // the pre-edge values; a later assignment in the block overrides an
    // earlier one (used for the frame-counter clear at the bottom).
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state         <= ST_BLANK;
            vsync_q       <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Pattern     <= 4'd0;
            frame_count   <= 8'd0;
            dir_next      <= 1'b0;
        end else begin
            vsync_q       <= i_VSync;
            o_Frame_Start <= frame_start_det;

            case (state)
                ST_BLANK: begin
                    if (frame_start_det) begin
                        state     <= ST_SHOW;
                        o_Pattern <= FIRST_P;
                    end
                end

                ST_SHOW: begin
                    if (frame_start_det && auto_active) begin
                        if (dwell_done) begin
                            o_Pattern   <= pattern_inc;
                            frame_count <= 8'd0;
                        end else begin
                            frame_count <= frame_count + 8'd1;
                        end
                    end
                    // A pulse on the frame-start cycle counts as arriving
                    // after that frame start, so it waits for the next one.
                    if (single_pulse) begin
                        state    <= ST_PENDING;
                        dir_next <= i_Next;
                    end
                end

                ST_PENDING: begin
                    if (frame_start_det) begin
                        // Manual step wins over auto-advance on this frame.
                        o_Pattern   <= dir_next ? pattern_inc : pattern_dec;
                        frame_count <= 8'd0;
                        if (single_pulse) begin
                            dir_next <= i_Next;
                        end else begin
                            state <= ST_SHOW;
                        end
                    end else if (single_pulse && (i_Next != dir_next)) begin
                        // Opposite direction cancels; same direction does
                        // not accumulate.
                        state <= ST_SHOW;
                    end
                end

                default: state <= ST_BLANK;
            endcase

            if (!auto_active) begin
                frame_count <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pattern_sequencer
//
// Directed bench for pattern_sequencer with default parameters (patterns 1..6).
// A table of per-cycle records holds the inputs driven for one clock and the
// outputs expected just after that clock edge; a hand-written sequence covers
// reset in the middle of a pending step.
// -----------------------------------------------------------------------------
module tb_pattern_sequencer;

    logic       i_Clk;
    logic       i_Rst;
    logic       i_VSync;
    logic       i_Next;
    logic       i_Prev;
    logic       i_Auto_En;
    logic [7:0] i_Frames_Per_Pattern;
    logic [3:0] o_Pattern;
    logic       o_Frame_Start;
    logic       o_Pending;

    int checks = 0;
    int errors = 0;

    pattern_sequencer dut (
        .i_Clk                (i_Clk),
        .i_Rst                (i_Rst),
        .i_VSync              (i_VSync),
        .i_Next               (i_Next),
        .i_Prev               (i_Prev),
        .i_Auto_En            (i_Auto_En),
        .i_Frames_Per_Pattern (i_Frames_Per_Pattern),
        .o_Pattern            (o_Pattern),
        .o_Frame_Start        (o_Frame_Start),
        .o_Pending            (o_Pending)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic       vs;
        logic       nx;
        logic       pv;
        logic       au;
        logic [7:0] fpp;
        logic [3:0] exp_pat;
        logic       exp_fs;
        logic       exp_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic vs, input logic nx, input logic pv,
                                input logic au, input logic [7:0] fpp,
                                input logic [3:0] pat, input logic fs,
                                input logic pend);
        vec_t v;
        v.vs = vs; v.nx = nx; v.pv = pv; v.au = au; v.fpp = fpp;
        v.exp_pat = pat; v.exp_fs = fs; v.exp_pend = pend;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s [step %0d]: got %0d, expected %0d",
                     name, idx, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then sample the outputs 1 ns after the edge.
    task automatic cycle(input logic rst, input logic vs, input logic nx,
                         input logic pv, input logic au, input logic [7:0] fpp);
        i_Rst = rst; i_VSync = vs; i_Next = nx; i_Prev = pv;
        i_Auto_En = au; i_Frames_Per_Pattern = fpp;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input int idx,
                              input logic [3:0] pat, input logic fs,
                              input logic pend);
        check({tag, ".pattern"}, idx, {4'd0, o_Pattern}, {4'd0, pat});
        check({tag, ".frame_start"}, idx, {7'd0, o_Frame_Start}, {7'd0, fs});
        check({tag, ".pending"}, idx, {7'd0, o_Pending}, {7'd0, pend});
    endtask

    initial begin
        // ---- vector table: vs nx pv au fpp | pattern fs pending ----
        // Blank until first frame start; Next ignored while blank.
        add(0,0,0, 0,8'd0, 4'd0,0,0);
        add(0,1,0, 0,8'd0, 4'd0,0,0);
        // Three frame starts with auto off: 1 after the first, stays 1.
        add(1,0,0, 0,8'd0, 4'd1,1,0);
        add(1,0,0, 0,8'd0, 4'd1,0,0);
        add(0,0,0, 0,8'd0, 4'd1,0,0);
        add(1,0,0, 0,8'd0, 4'd1,1,0);
        add(0,0,0, 0,8'd0, 4'd1,0,0);
        add(1,0,0, 0,8'd0, 4'd1,1,0);
        add(0,0,0, 0,8'd0, 4'd1,0,0);
        // Prev from the first pattern wraps to the last.
        add(0,0,1, 0,8'd0, 4'd1,0,1);
        add(0,0,0, 0,8'd0, 4'd1,0,1);
        add(1,0,0, 0,8'd0, 4'd6,1,0);
        add(0,0,0, 0,8'd0, 4'd6,0,0);
        // Next at the last pattern waits for the frame, then wraps to 1.
        add(0,1,0, 0,8'd0, 4'd6,0,1);
        add(0,0,0, 0,8'd0, 4'd6,0,1);
        add(1,0,0, 0,8'd0, 4'd1,1,0);
        add(0,0,0, 0,8'd0, 4'd1,0,0);
        // Walk up to pattern 3.
        add(0,1,0, 0,8'd0, 4'd1,0,1);
        add(1,0,0, 0,8'd0, 4'd2,1,0);
        add(0,0,0, 0,8'd0, 4'd2,0,0);
        add(0,1,0, 0,8'd0, 4'd2,0,1);
        add(1,0,0, 0,8'd0, 4'd3,1,0);
        add(0,0,0, 0,8'd0, 4'd3,0,0);
        // Next x3 does not accumulate; Prev cancels.
        add(0,1,0, 0,8'd0, 4'd3,0,1);
        add(0,1,0, 0,8'd0, 4'd3,0,1);
        add(0,1,0, 0,8'd0, 4'd3,0,1);
        add(0,0,1, 0,8'd0, 4'd3,0,0);
        add(1,0,0, 0,8'd0, 4'd3,1,0);
        add(0,0,0, 0,8'd0, 4'd3,0,0);
        // Next and Prev together are ignored.
        add(0,1,1, 0,8'd0, 4'd3,0,0);
        add(1,0,0, 0,8'd0, 4'd3,1,0);
        add(0,0,0, 0,8'd0, 4'd3,0,0);
        // Next on a frame-start cycle applies at the following frame start.
        add(1,1,0, 0,8'd0, 4'd3,1,1);
        add(0,0,0, 0,8'd0, 4'd3,0,1);
        add(1,0,0, 0,8'd0, 4'd4,1,0);
        add(0,0,0, 0,8'd0, 4'd4,0,0);
        // Auto-advance every 2 frames: 4,4,5,5,6,6,1 (wrap).
        add(0,0,0, 1,8'd2, 4'd4,0,0);
        add(1,0,0, 1,8'd2, 4'd4,1,0);
        add(0,0,0, 1,8'd2, 4'd4,0,0);
        add(1,0,0, 1,8'd2, 4'd5,1,0);
        add(0,0,0, 1,8'd2, 4'd5,0,0);
        add(1,0,0, 1,8'd2, 4'd5,1,0);
        add(0,0,0, 1,8'd2, 4'd5,0,0);
        add(1,0,0, 1,8'd2, 4'd6,1,0);
        add(0,0,0, 1,8'd2, 4'd6,0,0);
        add(1,0,0, 1,8'd2, 4'd6,1,0);
        add(0,0,0, 1,8'd2, 4'd6,0,0);
        add(1,0,0, 1,8'd2, 4'd1,1,0);
        add(0,0,0, 1,8'd2, 4'd1,0,0);
        // Count reaches 1, then dwell drops to 1 -> advance at next frame.
        add(1,0,0, 1,8'd2, 4'd1,1,0);
        add(0,0,0, 1,8'd1, 4'd1,0,0);
        add(1,0,0, 1,8'd1, 4'd2,1,0);
        add(0,0,0, 1,8'd1, 4'd2,0,0);
        // Manual step takes priority over auto-advance: single step only.
        add(0,1,0, 1,8'd1, 4'd2,0,1);
        add(1,0,0, 1,8'd1, 4'd3,1,0);
        add(0,0,0, 1,8'd1, 4'd3,0,0);
        add(1,0,0, 1,8'd1, 4'd4,1,0);
        add(0,0,0, 1,8'd1, 4'd4,0,0);
        // Dwell of 0 disables auto-advance.
        add(1,0,0, 1,8'd0, 4'd4,1,0);
        add(0,0,0, 1,8'd0, 4'd4,0,0);
        add(1,0,0, 1,8'd0, 4'd4,1,0);
        add(0,0,0, 1,8'd0, 4'd4,0,0);

        // ---- reset ----
        cycle(1, 0,0,0, 0,8'd0);
        cycle(1, 0,0,0, 0,8'd0);
        check_outs("reset", 0, 4'd0, 1'b0, 1'b0);

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(0, vecs[i].vs, vecs[i].nx, vecs[i].pv, vecs[i].au, vecs[i].fpp);
            check_outs("vec", i, vecs[i].exp_pat, vecs[i].exp_fs, vecs[i].exp_pend);
        end

        // ---- reset while pending at pattern 4 ----
        cycle(0, 0,1,0, 0,8'd0);
        check_outs("pend_before_rst", 0, 4'd4, 1'b0, 1'b1);
        // Reset wins over a simultaneous frame start and Next pulse.
        cycle(1, 1,1,0, 1,8'd1);
        check_outs("pend_rst", 0, 4'd0, 1'b0, 1'b0);
        cycle(0, 0,0,0, 0,8'd0);
        check_outs("after_rst_idle", 0, 4'd0, 1'b0, 1'b0);
        cycle(0, 1,0,0, 0,8'd0);
        check_outs("after_rst_frame", 0, 4'd1, 1'b1, 1'b0);
        cycle(0, 0,0,0, 0,8'd0);
        check_outs("after_rst_hold", 0, 4'd1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
